// File: rtl/jtag_chain1.sv
// jtag_chain1 -- JTAG user-data chain 1 (ER1 path of the FPGA JTAG primitive).
//
// A 36-bit data register is shifted LSB-first from the TAP and decoded on
// Update-DR as {payload[31:0], opcode[3:0]}. The chain holds the bus-master
// configuration (address, byte enable, burst size), a 16-word data buffer
// and a burst engine that fills the buffer from the parallel-port/bus side
// while the TAP sits in Run-Test/Idle with ER1 selected.
//
// Everything runs on JTCK; JRSTN is an asynchronous active-low reset.
//
// Build option:
//   CHAIN1_STATUS_READ_EN  when defined, opcode 0x7 loads the status register
//                          into the readback register; otherwise 0x7 is a NOP.

module jtag_chain1 (
    input  logic        JTCK,
    input  logic        JRSTN,
    input  logic        JTDI,
    input  logic        JSHIFT,
    input  logic        JUPDATE,
    input  logic        JRTI1,
    input  logic        JCE1,
    output logic        JTD1,
    input  logic [31:0] pp_dataOut,
    input  logic        switch_ready
);

    // Opcodes carried in the low nibble of the shifted word
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADDR   = 4'h1;
    localparam logic [3:0] OP_BE     = 4'h2;
    localparam logic [3:0] OP_BSIZE  = 4'h3;
    localparam logic [3:0] OP_RDADDR = 4'h4;
    localparam logic [3:0] OP_RDBE   = 4'h5;
    localparam logic [3:0] OP_RDBSZ  = 4'h6;
    localparam logic [3:0] OP_RDSTAT = 4'h7;
    localparam logic [3:0] OP_WRBUF  = 4'h8;
    localparam logic [3:0] OP_BURST  = 4'h9;
    localparam logic [3:0] OP_RDBUF  = 4'hA;

    logic [35:0] sr;
    logic [31:0] address_reg;
    logic [3:0]  byte_enable_reg;
    logic [7:0]  busrt_size_reg;
    logic [7:0]  status_reg;
    logic [35:0] out_reg;
    logic [31:0] buffer [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [7:0]  burst_cnt;
    logic        busy;
    logic        done;

    // Decoded view of the shift register at Update-DR
    logic [3:0]  op;
    logic [31:0] pl;

    // Per-cycle strobes
    logic        upd_addr;
    logic        upd_be;
    logic        upd_bsize;
    logic        upd_wrbuf;
    logic        upd_burst;
    logic        upd_rdbuf;
    logic        upd_readback;
    logic        burst_step;
    logic        burst_last;
    logic        buf_we;
    logic [31:0] buf_wdata;
    logic [35:0] readback_val;

    assign op = sr[3:0];
    assign pl = sr[35:4];

    // The serial output is simply the bottom of the shift register; it is
    // zero during reset because sr is cleared.
    assign JTD1 = sr[0];

    assign status_reg = {wr_ptr, 2'b00, done, busy};

    // Decode the update opcode into one-hot strobes and select readback data
    always_comb begin
        upd_addr     = 1'b0;
        upd_be       = 1'b0;
        upd_bsize    = 1'b0;
        upd_wrbuf    = 1'b0;
        upd_burst    = 1'b0;
        upd_rdbuf    = 1'b0;
        upd_readback = 1'b0;
        readback_val = out_reg;
        if (JUPDATE) begin
            case (op)
                OP_ADDR:   upd_addr  = 1'b1;
                OP_BE:     upd_be    = 1'b1;
                OP_BSIZE:  upd_bsize = 1'b1;
                OP_RDADDR: begin
                    upd_readback = 1'b1;
                    readback_val = {address_reg, op};
                end
                OP_RDBE: begin
                    upd_readback = 1'b1;
                    readback_val = {28'b0, byte_enable_reg, op};
                end
                OP_RDBSZ: begin
                    upd_readback = 1'b1;
                    readback_val = {24'b0, busrt_size_reg, op};
                end
`ifdef CHAIN1_STATUS_READ_EN
                OP_RDSTAT: begin
                    upd_readback = 1'b1;
                    readback_val = {24'b0, status_reg, op};
                end
`else
                OP_RDSTAT: ;
`endif
                // Host writes are dropped while the burst engine owns the buffer
                OP_WRBUF:  upd_wrbuf = !busy;
                OP_BURST:  upd_burst = 1'b1;
                OP_RDBUF: begin
                    upd_rdbuf    = 1'b1;
                    upd_readback = 1'b1;
                    readback_val = {buffer[rd_ptr], op};
                end
                OP_NOP:    ;
                default:   ;
            endcase
        end
    end

    // A burst (re)start on this edge takes precedence over stepping the
    // engine, so the first word lands on the next qualifying cycle.
    assign burst_step = busy && JRTI1 && switch_ready && !upd_burst;
    assign burst_last = burst_step && (burst_cnt == 8'd1);

    // Host writes and burst writes never coincide (host writes need !busy)
    assign buf_we    = upd_wrbuf || burst_step;
    assign buf_wdata = burst_step ? pp_dataOut : pl;

    // Data register: update holds, capture loads readback, shift moves LSB-first
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            sr <= '0;
        end else if (JUPDATE) begin
            sr <= sr;
        end else if (JCE1 && !JSHIFT) begin
            sr <= out_reg;
        end else if (JCE1 && JSHIFT) begin
            sr <= {JTDI, sr[35:1]};
        end
    end

    // Bus-master configuration registers written by update opcodes 0x1..0x3
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            address_reg     <= '0;
            byte_enable_reg <= '0;
            busrt_size_reg  <= '0;
        end else begin
            if (upd_addr)  address_reg     <= pl;
            if (upd_be)    byte_enable_reg <= pl[3:0];
            if (upd_bsize) busrt_size_reg  <= pl[7:0];
        end
    end

    // Readback register captured into sr at the next Capture-DR
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            out_reg <= '0;
        end else if (upd_readback) begin
            out_reg <= readback_val;
        end
    end

    // Buffer pointers and burst engine state
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (upd_burst) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                burst_cnt <= busrt_size_reg;
                busy      <= (busrt_size_reg != 8'd0);
                done      <= (busrt_size_reg == 8'd0);
            end else begin
                if (upd_wrbuf || burst_step) begin
                    wr_ptr <= wr_ptr + 4'd1;
                end
                if (upd_rdbuf) begin
                    rd_ptr <= rd_ptr + 4'd1;
                end
                if (burst_step) begin
                    burst_cnt <= burst_cnt - 8'd1;
                end
                if (burst_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Data buffer storage; contents survive reset
    always_ff @(posedge JTCK) begin
        if (buf_we) begin
            buffer[wr_ptr] <= buf_wdata;
        end
    end

endmodule

// File: tb/tb_jtag_chain1.sv
// tb_jtag_chain1 -- self-checking bench for jtag_chain1 with a behavioural
// model of the chain's registers, buffer and burst engine.

module tb_jtag_chain1;

    logic        JTCK = 1'b0;
    logic        JRSTN;
    logic        JTDI;
    logic        JSHIFT;
    logic        JUPDATE;
    logic        JRTI1;
    logic        JCE1;
    logic        JTD1;
    logic [31:0] pp_dataOut;
    logic        switch_ready;

    jtag_chain1 dut (
        .JTCK         (JTCK),
        .JRSTN        (JRSTN),
        .JTDI         (JTDI),
        .JSHIFT       (JSHIFT),
        .JUPDATE      (JUPDATE),
        .JRTI1        (JRTI1),
        .JCE1         (JCE1),
        .JTD1         (JTD1),
        .pp_dataOut   (pp_dataOut),
        .switch_ready (switch_ready)
    );

    always #5 JTCK = ~JTCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [7:0]  m_bs;
    logic [31:0] m_buf [16];
    int          m_wr;
    int          m_rd;
    int          m_cnt;
    bit          m_busy;
    bit          m_done;
    logic [35:0] m_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        logic [3:0] w;
        w = 4'(m_wr);
        return {w, 2'b00, m_done, m_busy};
    endfunction

    task automatic model_reset();
        m_addr = '0; m_be = '0; m_bs = '0;
        m_wr = 0; m_rd = 0; m_cnt = 0;
        m_busy = 0; m_done = 0; m_out = '0;
    endtask

    task automatic model_update(input logic [35:0] v);
        logic [3:0]  op;
        logic [31:0] pl;
        op = v[3:0];
        pl = v[35:4];
        case (op)
            4'h1: m_addr = pl;
            4'h2: m_be = pl[3:0];
            4'h3: m_bs = pl[7:0];
            4'h4: m_out = {m_addr, op};
            4'h5: m_out = {28'b0, m_be, op};
            4'h6: m_out = {24'b0, m_bs, op};
`ifdef CHAIN1_STATUS_READ_EN
            4'h7: m_out = {24'b0, m_status(), op};
`endif
            4'h8: if (!m_busy) begin
                m_buf[m_wr] = pl;
                m_wr = (m_wr + 1) % 16;
            end
            4'h9: begin
                m_wr = 0; m_rd = 0; m_cnt = int'(m_bs);
                m_busy = (m_bs != 0);
                m_done = (m_bs == 0);
            end
            4'hA: begin
                m_out = {m_buf[m_rd], op};
                m_rd = (m_rd + 1) % 16;
            end
            default: ;
        endcase
    endtask

    // Capture, 36 shifts and an update; returns the bits seen on JTD1
    task automatic shift_dr(input logic [35:0] din, output logic [35:0] dout);
        JRTI1 = 0;
        JCE1 = 1; JSHIFT = 0;
        @(negedge JTCK);
        JSHIFT = 1;
        for (int i = 0; i < 36; i++) begin
            dout[i] = JTD1;
            JTDI = din[i];
            @(negedge JTCK);
        end
        JCE1 = 0; JSHIFT = 0; JUPDATE = 1;
        @(negedge JTCK);
        JUPDATE = 0;
    endtask

    task automatic do_op(input string tag, input logic [35:0] din);
        logic [35:0] dout;
        logic [35:0] exp_out;
        exp_out = m_out;
        shift_dr(din, dout);
        check({tag, "_tdo"}, dout, exp_out);
        model_update(din);
        check({tag, "_status"}, dut.status_reg, m_status());
        check({tag, "_rdptr"}, dut.rd_ptr, m_rd);
    endtask

    // Run the burst engine until the model says it is finished
    task automatic run_burst(input string tag, input bit randq, input int maxc, output int busy_cycles);
        int c;
        bit rti, rdy;
        c = 0;
        busy_cycles = 0;
        while (m_busy && c < maxc) begin
            rti = randq ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = randq ? ($urandom_range(0, 3) != 0) : 1'b1;
            JRTI1 = rti;
            switch_ready = rdy;
            pp_dataOut = randq ? $urandom : 32'hFFFF_FFFF;
            if (dut.busy === 1'b1) busy_cycles++;
            @(negedge JTCK);
            if (rti && rdy && m_busy) begin
                m_buf[m_wr] = pp_dataOut;
                m_wr = (m_wr + 1) % 16;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            check({tag, "_cyc"}, dut.status_reg, m_status());
            c++;
        end
        check({tag, "_bound"}, m_busy, 1'b0);
        JRTI1 = 0;
        switch_ready = 0;
    endtask

    initial begin
        int bc;
        logic [3:0]  rop;
        logic [31:0] rpl;

        JRSTN = 0; JTDI = 0; JSHIFT = 0; JUPDATE = 0; JRTI1 = 0; JCE1 = 0;
        pp_dataOut = '0; switch_ready = 0;
        model_reset();
        repeat (3) @(negedge JTCK);
        check("rst_tdo", JTD1, 1'b0);
        check("rst_status", dut.status_reg, 8'h00);
        JRSTN = 1;
        @(negedge JTCK);

        // Configuration writes and readback
        do_op("addr_wr", 36'h5_5555_5551);
        do_op("addr_rd", 36'h4);
        do_op("addr_nop", 36'h0);
        check("addr_model", m_out, 36'h5_5555_5554);
        do_op("be_wr", 36'hE2);
        do_op("bs_wr", 36'h553);
        do_op("be_rd", 36'h5);
        do_op("be_nop", 36'h0);
        do_op("bs_rd", 36'h6);
        do_op("bs_nop", 36'h0);

        // Host buffer writes
        do_op("buf0", 36'h0_ABCD_EF8);
        do_op("buf1", 36'h1_ABCD_EF8);
        do_op("buf2", 36'h2_ABCD_EF8);
        check("wr_ptr3", dut.status_reg[7:4], 4'd3);

        // Fixed four-word burst with the bus always ready
        do_op("bs4", 36'h43);
        do_op("burst4", 36'h9);
        run_burst("burst4", 1'b0, 100, bc);
        check("burst4_busy_cycles", bc, 4);
        check("burst4_done", dut.done, 1'b1);
        do_op("rdbuf", 36'hA);
        do_op("rdbuf_nop", 36'h0);
        check("rdptr1", dut.rd_ptr, 4'd1);

        // Fill the whole buffer so later reads are well defined
        for (int i = 0; i < 16; i++) do_op("fill", {$urandom, 4'h8});

        // Zero-length burst completes at once
        do_op("bs0", 36'h03);
        do_op("burst0", 36'h9);
        check("burst0_done", dut.done, 1'b1);

        // Randomised operation mix with stalling bursts (sizes cover wrap)
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            rpl = $urandom;
            if (rop == 4'h3) rpl = $urandom_range(0, 20);
            do_op("rand", {rpl, rop});
            if (rop == 4'h9) run_burst("rburst", 1'b1, 2000, bc);
        end

        // Reset in the middle of a burst clears state immediately
        do_op("bs10", 36'hA3);
        do_op("burst10", 36'h9);
        for (int i = 0; i < 3; i++) begin
            JRTI1 = 1; switch_ready = 1; pp_dataOut = $urandom;
            @(negedge JTCK);
            m_buf[m_wr] = pp_dataOut;
            m_wr = (m_wr + 1) % 16;
            m_cnt--;
        end
        check("mid_busy", dut.busy, 1'b1);
        #2 JRSTN = 0;
        #1;
        check("mrst_busy", dut.busy, 1'b0);
        check("mrst_done", dut.done, 1'b0);
        check("mrst_tdo", JTD1, 1'b0);
        check("mrst_status", dut.status_reg, 8'h00);
        model_reset();
        JRTI1 = 0; switch_ready = 0;
        @(negedge JTCK);
        JRSTN = 1;
        @(negedge JTCK);
        do_op("stat_rd", 36'h7);
        do_op("stat_nop", 36'h0);
`ifdef CHAIN1_STATUS_READ_EN
        check("stat_model", m_out, 36'h0_0000_0007);
`else
        check("stat_model", m_out, 36'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
